// File: rtl/dff2_debounce.sv
// dff2_debounce: synchronous level filter feeding dff2.d.
// A new input level is accepted only after STABLE_CYCLES consecutive enabled
// samples of that level. Accepted transitions are flagged by one-cycle
// rise/fall pulses. busy is high while a candidate level is being confirmed.
//
// Optional build macro: DEBOUNCE_SYNC_EN
//   defined   - din passes through a 2-flop synchronizer; every latency grows by 2 clocks
//   undefined - din is sampled directly and must be synchronous to clk
//
// Handshake: none. din/en are plain levels sampled on every rising clk edge.
// Cycles with en=0 leave state, cnt and q untouched; rise/fall read 0 then.
// The FSM state is observable as busy (busy == state is CONFIRM).
module dff2_debounce #(
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_W         = 8,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } state_t;

    // The count value at which the next matching sample completes a confirmation.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;

`ifdef DEBOUNCE_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer; shifts every clock regardless of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = din;
`endif

    // Confirmation FSM with registered q, pulses and busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE;
            cnt   <= '0;
            q     <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                case (state)
                    STABLE: begin
                        if (s != q) begin
                            if (STABLE_CYCLES == 1) begin
                                // Single-sample acceptance: no confirm phase at all.
                                q    <= s;
                                rise <= s;
                                fall <= ~s;
                            end else begin
                                state <= CONFIRM;
                                cnt   <= CNT_W'(1);
                                busy  <= 1'b1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    CONFIRM: begin
                        if (s == q) begin
                            // Input bounced back: abandon the candidate silently.
                            state <= STABLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            q     <= s;
                            rise  <= s;
                            fall  <= ~s;
                            state <= STABLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
